// File: rtl/data_memory_mp_pkg.sv
// data_memory_mp_pkg: shared defaults, FSM encoding and sizing helper for the multi-port data memory.
// Revision: 1.0
`default_nettype none

package data_memory_mp_pkg;

  localparam int DMEM_WORD_SIZE  = 16;
  localparam int DMEM_ADDR_WIDTH = 16;
  localparam int DMEM_DEPTH      = 256;
  localparam int DMEM_NUM_RD     = 2;

  typedef enum logic [1:0] {
    DM_INIT  = 2'd0,
    DM_CLEAR = 2'd1,
    DM_READY = 2'd2
  } dm_state_e;

  // Counter width that still works for a single-word memory.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_mp_if.sv
// data_memory_mp_if: write port, NUM_RD read ports and status bundle of the data memory.
// Revision: 1.0
`default_nettype none

interface data_memory_mp_if
  import data_memory_mp_pkg::*;
#(
  parameter int WORD_SIZE  = DMEM_WORD_SIZE,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int NUM_RD     = DMEM_NUM_RD
);

  logic [ADDR_WIDTH-1:0]        memaddr_w;
  logic [WORD_SIZE-1:0]         memval;
  logic                         memset;
  logic [NUM_RD*ADDR_WIDTH-1:0] memaddr_r;
  logic [NUM_RD-1:0]            memget;
  logic [NUM_RD*WORD_SIZE-1:0]  memout;
  logic [NUM_RD-1:0]            memout_valid;
  logic                         busy;
  logic                         addr_err;

  modport master (
    output memaddr_w, memval, memset, memaddr_r, memget,
    input  memout, memout_valid, busy, addr_err
  );

  modport slave (
    input  memaddr_w, memval, memset, memaddr_r, memget,
    output memout, memout_valid, busy, addr_err
  );

endinterface

`default_nettype wire

// File: rtl/data_memory_mp_read_port.sv
// dmem_read_port: one registered read port with range check and write-first bypass.
// Revision: 1.0
`default_nettype none

module dmem_read_port
  import data_memory_mp_pkg::*;
#(
  parameter int WORD_SIZE  = DMEM_WORD_SIZE,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH
) (
  input  wire logic                  mclk,
  input  wire logic                  rst_n,
  input  wire logic                  i_en,
  input  wire logic [ADDR_WIDTH-1:0] i_addr,
  input  wire logic [WORD_SIZE-1:0]  i_mem_word,
  input  wire logic                  i_wr_en,
  input  wire logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  wire logic [WORD_SIZE-1:0]  i_wr_data,
  output logic [WORD_SIZE-1:0]       o_data,
  output logic                       o_valid,
  output logic                       o_err
);

  logic                 w_in_range;
  logic                 w_bypass;
  logic [WORD_SIZE-1:0] w_word;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_valid;
  logic                 r_err;

  // Extra top bit keeps the compare exact when DEPTH == 2**ADDR_WIDTH.
  assign w_in_range = ({1'b0, i_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  // i_wr_en is only raised for in-range writes, so a hit implies an in-range read.
  assign w_bypass   = i_wr_en && (i_wr_addr == i_addr);
  assign w_word     = w_bypass ? i_wr_data : i_mem_word;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= i_en;
      r_err   <= i_en && !w_in_range;
      if (i_en) begin
        r_data <= w_in_range ? w_word : '0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/data_memory_mp.sv
// data_memory_mp: DEPTH-word store with one write port, NUM_RD registered read ports and a post-reset clear.
// Revision: 1.0
`default_nettype none

module data_memory_mp
  import data_memory_mp_pkg::*;
#(
  parameter int WORD_SIZE  = DMEM_WORD_SIZE,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int NUM_RD     = DMEM_NUM_RD
) (
  input wire logic mclk,
  input wire logic rst_n,
  data_memory_mp_if.slave bus
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [WORD_SIZE-1:0]        r_mem [DEPTH];
  dm_state_e                   r_state;
  logic [CNT_W-1:0]            r_clr_cnt;
  logic                        r_busy;
  logic                        r_wr_err;

  logic                        w_ready;
  logic                        w_wr_in_range;
  logic                        w_usr_we;
  logic                        w_mem_we;
  logic [CNT_W-1:0]            w_mem_waddr;
  logic [WORD_SIZE-1:0]        w_mem_wdata;
  logic [NUM_RD*WORD_SIZE-1:0] w_memout;
  logic [NUM_RD-1:0]           w_memout_valid;
  logic [NUM_RD-1:0]           w_port_err;

  assign w_ready       = (r_state == DM_READY);
  assign w_wr_in_range = ({1'b0, bus.memaddr_w} < (ADDR_WIDTH + 1)'(DEPTH));
  assign w_usr_we      = w_ready && bus.memset && w_wr_in_range;

  // Clear and user writes share the single array write port.
  assign w_mem_we    = !w_ready || w_usr_we;
  assign w_mem_waddr = w_ready ? bus.memaddr_w[CNT_W-1:0] : r_clr_cnt;
  assign w_mem_wdata = w_ready ? bus.memval : '0;

  // INIT already writes address 0, so busy drops on the DEPTH-th edge.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DM_INIT;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_err <= 1'b0;
      case (r_state)
        DM_INIT, DM_CLEAR: begin
          if (r_clr_cnt == CNT_W'(DEPTH - 1)) begin
            r_state   <= DM_READY;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
          end else begin
            r_state   <= DM_CLEAR;
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        DM_READY: begin
          r_wr_err <= bus.memset && !w_wr_in_range;
        end
        default: begin
          r_state   <= DM_INIT;
          r_clr_cnt <= '0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
    logic [ADDR_WIDTH-1:0] w_raddr;
    assign w_raddr = bus.memaddr_r[k*ADDR_WIDTH +: ADDR_WIDTH];

    dmem_read_port #(
      .WORD_SIZE  (WORD_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_rd_port (
      .mclk       (mclk),
      .rst_n      (rst_n),
      .i_en       (w_ready && bus.memget[k]),
      .i_addr     (w_raddr),
      .i_mem_word (r_mem[w_raddr[CNT_W-1:0]]),
      .i_wr_en    (w_usr_we),
      .i_wr_addr  (bus.memaddr_w),
      .i_wr_data  (bus.memval),
      .o_data     (w_memout[k*WORD_SIZE +: WORD_SIZE]),
      .o_valid    (w_memout_valid[k]),
      .o_err      (w_port_err[k])
    );
  end

  assign bus.memout       = w_memout;
  assign bus.memout_valid = w_memout_valid;
  assign bus.busy         = r_busy;
  assign bus.addr_err     = r_wr_err || (|w_port_err);

endmodule

`default_nettype wire

// File: tb/tb_data_memory_mp.sv
// tb_data_memory_mp: table-driven scoreboard bench for data_memory_mp at DEPTH=8, NUM_RD=2.
// Revision: 1.0
`default_nettype none

module tb_data_memory_mp;

  localparam int WS  = 16;
  localparam int AW  = 16;
  localparam int DEP = 8;
  localparam int NR  = 2;

  typedef struct {
    logic        we;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [1:0]  get;
    logic [15:0] ra0;
    logic [15:0] ra1;
    logic [1:0]  ev;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [1:0]  v;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        err;
  } exp_t;

  logic mclk  = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[$];
  exp_t sb[$];

  data_memory_mp_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

  data_memory_mp #(
    .WORD_SIZE  (WS),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEP),
    .NUM_RD     (NR)
  ) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h, required %h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                       input logic [1:0] get, input logic [15:0] ra0, input logic [15:0] ra1);
    bus.memset    = we;
    bus.memaddr_w = wa;
    bus.memval    = wd;
    bus.memget    = get;
    bus.memaddr_r = {ra1, ra0};
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    drive(v.we, v.wa, v.wd, v.get, v.ra0, v.ra1);
    e.v = v.ev; e.d0 = v.e0; e.d1 = v.e1; e.err = v.eerr;
    sb.push_back(e);
    @(posedge mclk); #1;
    e = sb.pop_front();
    chk("valid",    {30'd0, bus.memout_valid}, {30'd0, e.v});
    chk("memout0",  {16'd0, bus.memout[15:0]}, {16'd0, e.d0});
    chk("memout1",  {16'd0, bus.memout[31:16]}, {16'd0, e.d1});
    chk("addr_err", {31'd0, bus.addr_err}, {31'd0, e.err});
    chk("busy",     {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic clear_phase();
    for (int i = 1; i <= DEP; i++) begin
      @(posedge mclk); #1;
      chk("clr_busy",  {31'd0, bus.busy}, {31'd0, (i < DEP)});
      chk("clr_valid", {30'd0, bus.memout_valid}, 32'd0);
      chk("clr_err",   {31'd0, bus.addr_err}, 32'd0);
    end
  endtask

  initial begin
    // we, wa, wd, get, ra0, ra1 | valid, memout0, memout1, addr_err
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h0005, 16'h0003, 2'b11, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0001, 16'h0001, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0002, 16'h0004, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0003, 16'h0009, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h0002, 16'h0003, 2'b11, 16'h0004, 16'h0009, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0004, 16'h0009, 1'b0});
    vecs.push_back('{1'b1, 16'h0004, 16'h1234, 2'b11, 16'h0004, 16'h0004, 2'b11, 16'h1234, 16'h1234, 1'b0});
    vecs.push_back('{1'b1, 16'h0008, 16'h5555, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h1234, 16'h1234, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b10, 16'h0000, 16'h0008, 2'b10, 16'h1234, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b01, 16'h0000, 16'h0000, 2'b01, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h0001, 16'h0003, 2'b11, 16'h0001, 16'h0009, 1'b0});
    vecs.push_back('{1'b1, 16'h0005, 16'hBEEF, 2'b01, 16'h0005, 16'h0000, 2'b01, 16'hBEEF, 16'h0009, 1'b0});
    vecs.push_back('{1'b1, 16'h0104, 16'h7777, 2'b11, 16'h0104, 16'h0005, 2'b11, 16'h0000, 16'hBEEF, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h0004, 16'h0102, 2'b11, 16'h1234, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h0001, 16'h0002, 2'b11, 16'h0001, 16'h0004, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h0003, 16'h0005, 2'b11, 16'h0009, 16'hBEEF, 1'b0});

    drive(1'b0, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    chk("rst_memout",   bus.memout, 32'd0);
    chk("rst_valid",    {30'd0, bus.memout_valid}, 32'd0);
    chk("rst_busy",     {31'd0, bus.busy}, 32'd1);
    chk("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);

    // Requests held across the whole clear must all be dropped.
    drive(1'b1, 16'h0003, 16'hAAAA, 2'b11, 16'h0005, 16'h0008);
    rst_n = 1'b1;
    clear_phase();

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset while a read result is on the outputs.
    drive(1'b0, 16'h0, 16'h0, 2'b11, 16'h0001, 16'h0002);
    @(posedge mclk); #1;
    chk("pre_rst_valid",  {30'd0, bus.memout_valid}, 32'd3);
    chk("pre_rst_memout", bus.memout, 32'h0004_0001);
    rst_n = 1'b0;
    #1;
    chk("async_memout",   bus.memout, 32'd0);
    chk("async_valid",    {30'd0, bus.memout_valid}, 32'd0);
    chk("async_busy",     {31'd0, bus.busy}, 32'd1);
    chk("async_addr_err", {31'd0, bus.addr_err}, 32'd0);
    drive(1'b0, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
    @(posedge mclk); #1;
    rst_n = 1'b1;
    clear_phase();
    apply('{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h0001, 16'h0002, 2'b11, 16'h0000, 16'h0000, 1'b0});
    apply('{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h0004, 16'h0005, 2'b11, 16'h0000, 16'h0000, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_memory_mp.md
# data_memory_mp

Parametrised successor to the single-port `data_memory`. It provides one write port and `NUM_RD` independent registered read ports over a `DEPTH`-word array. After reset it runs a hardware clear sequence, and it flags out-of-range accesses. It sits between the datapath/load-store unit and the ssd/FPGA self-check harness as the CPU data store.

## Interface
- `WORD_SIZE`, 16: data width in bits (from `parameters.vh`).
- `ADDR_WIDTH`, 16: address bus width.
- `DEPTH`, 256: number of words; legal addresses are 0..DEPTH-1; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- `NUM_RD`, 2: number of read ports, ≥1.

Ports:
- `mclk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `memaddr_w` input ADDR_WIDTH: write address.
- `memval` input WORD_SIZE: write data.
- `memset` input 1: write strobe.
- `memaddr_r` input NUM_RD*ADDR_WIDTH: read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `memget` input NUM_RD: per-port read strobe.
- `memout` output NUM_RD*WORD_SIZE: per-port read data, packed like `memaddr_r`.
- `memout_valid` output NUM_RD: per-port read-data-valid pulse.
- `busy` output 1: clear sequence in progress; requests are ignored while high.
- `addr_err` output 1: one-cycle pulse when any accepted access is out of range.

## Operation
- FSM states:
  - INIT: entered asynchronously on `rst_n` low. Clear counter = 0.
  - CLEAR: on each edge, writes 0 to address `clr_cnt`, then increments. Leaves after writing DEPTH-1.
  - READY: steady state. Any `rst_n` assertion returns to INIT from any state.
  - INIT→CLEAR on the first edge with `rst_n` high.
- While `busy`=1, `memset`/`memget` are dropped silently: no write, no valid, no `addr_err`.
- Write in READY: when `memset`=1 and `memaddr_w` < DEPTH, write `memval` on the edge. When `memaddr_w` ≥ DEPTH, drop the write and pulse `addr_err`.
- Read in READY, per port k, independent of the other ports:
  - `memget[k]`=1 with an in-range address: `memout[k]` loads the word on the edge and `memout_valid[k]` pulses.
  - Out-of-range address: `memout[k]` loads 0, `memout_valid[k]` still pulses, and `addr_err` pulses.
- Same-edge write and read to the same in-range address: write-first, so the read returns the new `memval`. This applies to every port simultaneously.
- Multiple reads of the same address on the same edge are all served.
- `memout[k]` holds its last value when `memget[k]`=0.
- `addr_err` is the OR over all ports and the write port. It is not sticky.
- Address comparisons are unsigned at full ADDR_WIDTH. Upper bits are never truncated before the range check.

## Timing
- Reset values: `memout`=0 for all ports, `memout_valid`=0, `busy`=1, `addr_err`=0. Array contents are undefined until CLEAR completes.
- Clear duration: DEPTH edges after the first edge with `rst_n` high. `busy` falls on the same edge that writes address DEPTH-1. The first accepted request is on the following edge.
- Read latency: 1 cycle. A request sampled at edge N gives `memout`/`memout_valid` valid after edge N, for exactly one cycle for the valid pulse.
- Write latency: 0 for visibility on the same edge (write-first). Reads at edge N+1 see the data.
- `rst_n` asserted mid-CLEAR or mid-READY: all outputs go to reset values immediately, without waiting for a clock edge. The clear restarts from address 0.
- Back-to-back reads every cycle are fully pipelined; there is no stall.

## Structure
- Add to `parameters.vh`:
  - `DMEM_DEPTH`.
  - `DMEM_NUM_RD`.
  - FSM state encodings `DM_INIT`, `DM_CLEAR`, `DM_READY` (2-bit).
- Sub-module `dmem_read_port` (one instance per port, via generate) handles:
  - address range check;
  - write-first bypass mux;
  - `memout` and `memout_valid` registers;
  - per-port error bit.
- The top level owns the array, clear FSM/counter, write path, and `addr_err` OR.

## Test plan
- Clear: DEPTH=8, NUM_RD=2. Release `rst_n` at t0. `busy`=1 for exactly 8 edges. A read of addr 5 issued on the first edge with `busy` low returns 0 with `memout_valid`=1.
- Busy drop: assert `memset` addr 3, val 16'hAAAA during CLEAR. After clear, reading addr 3 returns 0 and `addr_err` never pulses.
- Write then read: write 1←16'h1, 2←16'h4, 3←16'h9. Then port0 reads 2 and port1 reads 3 on the same edge → 16'h4 / 16'h9, both valid one cycle later.
- Write-first collision: write 4←16'h1234 while port0 and port1 both read 4 on the same edge → both return 16'h1234.
- Range error: write addr 8 val 16'h5555 → `addr_err` pulses once. Port1 reads 8 → `memout[1]`=0 with valid and `addr_err`. A later read of 0 is unaffected.
- Reset mid-run: assert `rst_n` low during a read cycle → `memout`=0, `memout_valid`=0, `busy`=1 immediately. After release, a full 8-edge clear occurs and prior data reads back 0.
